// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder.
// Holds the FSM state encoding and the default parameter values so that the
// responder and anything that models it agree on them.
package mem_responder_pkg;

   // Default geometry and latency.
   localparam int unsigned DefDepth      = 1024;
   localparam int unsigned DefWaitCycles = 1;

   // FSM state encoding.
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

endpackage

// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// One transaction in flight at a time: IDLE accepts, WAIT burns WAIT_CYCLES
// cycles (skipped when WAIT_CYCLES = 0), RESP holds the response until taken.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted this cycle (IDLE only)
//   req_we     1 = write, 0 = read
//   req_addr   byte address (must be word aligned and inside the array)
//   req_wdata  write data
//   req_be     byte enables, bit i covers wdata[8i+7:8i]
//   rsp_valid  response present
//   rsp_ready  requester takes the response
//   rsp_rdata  read data (0 for writes, errors and when idle)
//   rsp_err    misaligned or out-of-range access
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH       = DefDepth,
   parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned Aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]  state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        ready_en_q;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [31:0] ramdata [DEPTH];

   logic        accept;
   logic        enter_resp;
   logic        cur_we;
   logic [31:0] cur_addr, cur_wdata;
   logic [3:0]  cur_be;
   logic        addr_err;
   logic [Aw-1:0] word_idx;
   logic [31:0] rd_word;
   logic [31:0] merged_word;

   // ready_en_q keeps req_ready low while clr is asserted and rises on the
   // first edge after release, even though the FSM already sits in IDLE.
   assign req_ready = ready_en_q && (state_q == StIdle);
   assign accept    = req_valid && req_ready;

   // With no wait state the memory is accessed on the acceptance edge itself,
   // so the live request is used; otherwise the latched copy is used.
   assign cur_we    = (state_q == StIdle) ? req_we    : we_q;
   assign cur_addr  = (state_q == StIdle) ? req_addr  : addr_q;
   assign cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
   assign cur_be    = (state_q == StIdle) ? req_be    : be_q;

   assign addr_err = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= DEPTH);
   assign word_idx = cur_addr[Aw+1:2];
   assign rd_word  = ramdata[word_idx];

   assign enter_resp = ((state_q == StIdle) && accept && (WAIT_CYCLES == 0)) ||
                       ((state_q == StWait) && (wait_cnt_q == 4'd0));

   // Byte-lane merge of the write data over the stored word.
   always_comb begin
      merged_word = rd_word;
      for (int i = 0; i < 4; i++) begin
         if (cur_be[i]) begin
            merged_word[8*i +: 8] = cur_wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         StIdle: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = StResp;
               end else begin
                  state_d    = StWait;
                  wait_cnt_d = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         StWait: begin
            if (wait_cnt_q == 4'd0) begin
               state_d = StResp;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (enter_resp) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = addr_err;
         rsp_rdata_d = (addr_err || cur_we) ? 32'd0 : rd_word;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= StIdle;
         wait_cnt_q  <= 4'd0;
         ready_en_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         ready_en_q  <= 1'b1;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Request capture so later changes on req_* cannot disturb the transaction.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
      end else if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
   end

   // Storage is never reset. A commit needs the FSM to reach RESP, which the
   // asynchronous reset prevents for any aborted transaction.
   always_ff @(posedge clk) begin
      if (enter_resp && cur_we && !addr_err) begin
         ramdata[word_idx] <= merged_word;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES = 1 and 0) driven with
// directed and randomized transactions against a word-array reference model.
module tb_mem_responder;

   localparam int unsigned Depth = 32;

   logic        clk = 1'b0;
   logic        clr       [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   logic [31:0] mdl [2][Depth];
   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH(Depth), .WAIT_CYCLES(0)) u_dut0 (
      .clk       (clk),
      .clr       (clr[0]),
      .req_valid (req_valid[0]),
      .req_ready (req_ready[0]),
      .req_we    (req_we[0]),
      .req_addr  (req_addr[0]),
      .req_wdata (req_wdata[0]),
      .req_be    (req_be[0]),
      .rsp_valid (rsp_valid[0]),
      .rsp_ready (rsp_ready[0]),
      .rsp_rdata (rsp_rdata[0]),
      .rsp_err   (rsp_err[0])
   );

   mem_responder #(.DEPTH(Depth), .WAIT_CYCLES(1)) u_dut1 (
      .clk       (clk),
      .clr       (clr[1]),
      .req_valid (req_valid[1]),
      .req_ready (req_ready[1]),
      .req_we    (req_we[1]),
      .req_addr  (req_addr[1]),
      .req_wdata (req_wdata[1]),
      .req_be    (req_be[1]),
      .rsp_valid (rsp_valid[1]),
      .rsp_ready (rsp_ready[1]),
      .rsp_rdata (rsp_rdata[1]),
      .rsp_err   (rsp_err[1])
   );

   function automatic int wait_of(input int k);
      return (k == 1) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h, required %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: aligned in-range accesses hit the array, everything else errs.
   task automatic model_txn(input int k, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output logic [31:0] rdata, output logic err);
      err   = (addr % 4 != 0) || (addr / 4 >= Depth);
      rdata = 32'd0;
      if (!err) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mdl[k][addr / 4][8*b +: 8] = wdata[8*b +: 8];
            end
         end else begin
            rdata = mdl[k][addr / 4];
         end
      end
   endtask

   function automatic logic [31:0] dut_word(input int k, input int i);
      return (k == 0) ? u_dut0.ramdata[i] : u_dut1.ramdata[i];
   endfunction

   // One complete transaction; called at a sample point (#1 after an edge).
   task automatic txn(input int k, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold,
                      output logic [31:0] rdata, output logic err);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          n;
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      req_be[k]    = be;
      n = 0;
      while (req_ready[k] !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      check("req_ready_seen", 32'(req_ready[k]), 32'd1);
      step();
      model_txn(k, we, addr, wdata, be, exp_rd, exp_err);
      // Scramble the request lines: the accepted transaction must not notice.
      req_valid[k] = 1'b0;
      req_we[k]    = 1'($urandom);
      req_addr[k]  = $urandom;
      req_wdata[k] = $urandom;
      req_be[k]    = 4'($urandom);
      n = 0;
      while (rsp_valid[k] !== 1'b1 && n < 20) begin
         check("quiet_outputs", rsp_rdata[k] | 32'(rsp_err[k]), 32'd0);
         step();
         n++;
      end
      check("rsp_latency", n, wait_of(k));
      for (int h = 0; h < hold; h++) begin
         // A competing request while the response is pending must be ignored.
         req_valid[k] = 1'b1;
         req_we[k]    = 1'b1;
         req_addr[k]  = 4 * $urandom_range(0, Depth - 1);
         req_be[k]    = 4'hf;
         check("hold_valid", 32'(rsp_valid[k]), 32'd1);
         check("hold_rdata", rsp_rdata[k], exp_rd);
         check("hold_ready_low", 32'(req_ready[k]), 32'd0);
         step();
      end
      req_valid[k] = 1'b0;
      check("rsp_rdata", rsp_rdata[k], exp_rd);
      check("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
      rdata = rsp_rdata[k];
      err   = rsp_err[k];
      rsp_ready[k] = 1'b1;
      step();
      rsp_ready[k] = 1'b0;
      check("rsp_valid_drop", 32'(rsp_valid[k]), 32'd0);
      check("rsp_idle_zero", rsp_rdata[k] | 32'(rsp_err[k]), 32'd0);
      check("req_ready_after", 32'(req_ready[k]), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [31:0] a;
      int          acc_edge [6];
      int          nacc, nrsp, cyc;
      logic        will_acc, will_rsp;

      for (int k = 0; k < 2; k++) begin
         clr[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
         req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b0;
      end
      step(); step(); step();
      for (int k = 0; k < 2; k++) begin
         check("reset_req_ready", 32'(req_ready[k]), 32'd0);
         check("reset_rsp", {rsp_rdata[k][30:0], rsp_valid[k]} | 32'(rsp_err[k]), 32'd0);
         clr[k] = 1'b1;
      end
      #2;
      check("ready_before_first_edge", 32'(req_ready[1]), 32'd0);
      step();
      for (int k = 0; k < 2; k++) check("ready_after_release", 32'(req_ready[k]), 32'd1);

      // Fill both arrays so every word is known.
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < Depth; i++) txn(k, 1'b1, 32'(4 * i), $urandom, 4'hf, 0, rd, er);

      txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hf, 0, rd, er);
      txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
      check("read_deadbeef", rd, 32'hDEADBEEF);

      txn(1, 1'b1, 32'h20, 32'hAAAAAAAA, 4'hf, 0, rd, er);
      txn(1, 1'b1, 32'h20, 32'h11223344, 4'b0101, 0, rd, er);
      check("write_rdata_zero", rd, 32'd0);
      txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
      check("be_merge", rd, 32'hAA22AA44);
      txn(1, 1'b1, 32'h20, 32'h55555555, 4'b0000, 0, rd, er);
      check("be_zero_err", 32'(er), 32'd0);
      txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
      check("be_zero_noop", rd, 32'hAA22AA44);

      txn(1, 1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er);
      check("misaligned_err", 32'(er), 32'd1);
      txn(1, 1'b0, 32'(4 * Depth), 32'h0, 4'h0, 0, rd, er);
      check("oob_err", 32'(er), 32'd1);
      check("oob_rdata", rd, 32'd0);
      txn(1, 1'b1, 32'(4 * Depth), 32'hFFFFFFFF, 4'hf, 0, rd, er);
      check("oob_write_err", 32'(er), 32'd1);

      txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);

      // Abort a write to 0x08 during WAIT.
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h08;
      req_wdata[1] = ~mdl[1][2]; req_be[1] = 4'hf;
      cyc = 0;
      while (req_ready[1] !== 1'b1 && cyc < 10) begin step(); cyc++; end
      step();
      req_valid[1] = 1'b0;
      #2 clr[1] = 1'b0;
      #1;
      check("abort_req_ready", 32'(req_ready[1]), 32'd0);
      check("abort_rsp", {rsp_rdata[1][30:0], rsp_valid[1]} | 32'(rsp_err[1]), 32'd0);
      step();
      check("abort_hold_ready", 32'(req_ready[1]), 32'd0);
      clr[1] = 1'b1;
      #2;
      check("abort_ready_pre_edge", 32'(req_ready[1]), 32'd0);
      step();
      check("abort_ready_post_edge", 32'(req_ready[1]), 32'd1);
      check("abort_no_rsp", 32'(rsp_valid[1]), 32'd0);
      step();
      check("abort_no_commit", dut_word(1, 2), mdl[1][2]);
      txn(1, 1'b0, 32'h08, 32'h0, 4'h0, 0, rd, er);

      // Back-to-back reads on the zero-wait instance, req_valid held high.
      nacc = 0; nrsp = 0; cyc = 0;
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0; rsp_ready[0] = 1'b1;
      while (nrsp < 6 && cyc < 60) begin
         will_acc = req_valid[0] && req_ready[0];
         will_rsp = rsp_valid[0] && rsp_ready[0];
         if (will_rsp) begin
            check("b2b_rdata", rsp_rdata[0], mdl[0][nrsp]);
            check("b2b_latency", (cyc + 1) - acc_edge[nrsp], 1);
            nrsp++;
         end
         if (will_acc) begin
            acc_edge[nacc] = cyc + 1;
            if (nacc > 0) check("b2b_spacing", acc_edge[nacc] - acc_edge[nacc-1], 2);
            nacc++;
         end
         step();
         cyc++;
         if (will_acc) begin
            req_addr[0] = 32'(4 * nacc);
            if (nacc == 6) req_valid[0] = 1'b0;
         end
      end
      rsp_ready[0] = 1'b0;
      check("b2b_count", nrsp, 6);
      step();

      // Randomized traffic.
      for (int t = 0; t < 80; t++) begin
         int k;
         int sel;
         k   = $urandom_range(0, 1);
         sel = $urandom_range(0, 9);
         if (sel == 0) a = 32'(4 * $urandom_range(0, Depth - 1) + $urandom_range(1, 3));
         else if (sel == 1) a = 32'(4 * Depth + 4 * $urandom_range(0, 1000));
         else a = 32'(4 * $urandom_range(0, Depth - 1));
         txn(k, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
      end

      for (int k = 0; k < 2; k++)
         for (int i = 0; i < Depth; i++) check("final_ram", dut_word(k, i), mdl[k][i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
